// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: controller states and the
// seven-segment code table (bit order gfedcba, active-high).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Non-BCD nibbles blank the digit rather than showing garbage.
  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade: counts 0..9 when enabled, carry is combinational so a
// full chain of decades rolls over on the same clock edge.
module bcd_decade (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  output logic [3:0] digit_o,
  output logic       carry_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next digit: wrap 9 -> 0 when enabled, hold otherwise.
  always_comb begin
    digit_d = digit_q;
    if (en_i) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;
  assign carry_o = en_i && (digit_q == 4'd9);

endmodule

// File: rtl/bcd_stopwatch.sv
// BCD stopwatch: start/stop and lap edge detection, IDLE/RUN/PAUSE control,
// tick prescaler, cascaded BCD decades, lap freeze and registered 7-seg out.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 1000000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    lap,
  output logic [7*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    lap_hold,
  output logic                    overflow,
  output logic [1:0]              state_dbg
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0] SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic [7*NUM_DIGITS-1:0] DIGITS_ZERO = {NUM_DIGITS{SEG_0 ^ SEG_MASK}};

  sw_state_e                 state_q;
  logic                      running_q;
  logic                      ss_q;
  logic                      lap_in_q;
  logic [PW-1:0]             presc_q;
  logic                      tick_q;
  logic                      lap_hold_q;
  logic [4*NUM_DIGITS-1:0]   lap_val_q;
  logic                      overflow_q;
  logic [7*NUM_DIGITS-1:0]   digits_q;
  logic [7*NUM_DIGITS-1:0]   seg_d;
  logic [4*NUM_DIGITS-1:0]   disp_d;
  logic [4*NUM_DIGITS-1:0]   count_w;
  logic [NUM_DIGITS:0]       en_chain;
  logic                      ss_rise;
  logic                      lap_rise;

  assign ss_rise  = start_stop && !ss_q;
  assign lap_rise = lap && !lap_in_q;

  // Previous-cycle input levels; reset loads the live level so a held input
  // does not produce a phantom edge after release.
  always_ff @(posedge clk) begin
    ss_q     <= start_stop;
    lap_in_q <= lap;
  end

  // Run/pause controller; running is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else if (ss_rise) begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          state_q   <= ST_RUN;
          running_q <= 1'b1;
        end
        ST_RUN: begin
          state_q   <= ST_PAUSE;
          running_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler advances only while RUN and keeps its phase across a pause.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (state_q == ST_RUN) begin
        if (presc_q == PRE_LAST) begin
          presc_q <= '0;
          tick_q  <= 1'b1;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

  assign en_chain[0] = tick_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_decade
    bcd_decade u_decade (
      .clk     (clk),
      .reset   (reset),
      .en_i    (en_chain[g]),
      .digit_o (count_w[4*g +: 4]),
      .carry_o (en_chain[g+1])
    );
  end

  // Sticky overflow on carry out of the top decade.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (en_chain[NUM_DIGITS]) begin
      overflow_q <= 1'b1;
    end
  end

  // Lap capture/release; a simultaneous start_stop edge wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_hold_q <= 1'b0;
      lap_val_q  <= '0;
    end else if (lap_rise && !ss_rise) begin
      if (lap_hold_q) begin
        lap_hold_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
        lap_hold_q <= 1'b1;
        lap_val_q  <= count_w;
      end
    end
  end

  // Select the displayed value and encode each decade.
  always_comb begin
    disp_d = lap_hold_q ? lap_val_q : count_w;
    seg_d  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_d[7*i +: 7] = seg_encode(disp_d[4*i +: 4]) ^ SEG_MASK;
    end
  end

  // Registered segment outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= DIGITS_ZERO;
    end else begin
      digits_q <= seg_d;
    end
  end

  assign digits    = digits_q;
  assign running   = running_q;
  assign lap_hold  = lap_hold_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch (2 digits, tick every 4 clocks, active-high
// segments). Driver pushes the expected post-edge outputs of an arithmetic
// reference model; a monitor pops one entry after every clock edge.
module tb_bcd_stopwatch;

  localparam int ND = 2;
  localparam int TD = 4;
  localparam int DW = 7 * ND;
  localparam int EW = DW + 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_stop = 1'b0;
  logic          lap = 1'b0;
  logic [DW-1:0] digits;
  logic          running;
  logic          lap_hold;
  logic          overflow;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  bcd_stopwatch #(
    .NUM_DIGITS     (ND),
    .TICK_DIV       (TD),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .digits     (digits),
    .running    (running),
    .lap_hold   (lap_hold),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [6:0] seg_tab[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 run, 2 pause. count is the live value 0..99.
  int            mode_m = 0;
  int            count_m = 0;
  int            lap_m = 0;
  int            run_cycles_m = 0;
  bit            pend_m = 0;
  bit            hold_m = 0;
  bit            ovf_m = 0;
  bit            ss_prev_m = 0;
  bit            lap_prev_m = 0;
  logic [DW-1:0] disp_m;

  function automatic logic [DW-1:0] enc(input int v);
    logic [DW-1:0] r;
    r[6:0]  = seg_tab[v % 10];
    r[13:7] = seg_tab[(v / 10) % 10];
    return r;
  endfunction

  task automatic model_step(input bit rst, input bit ss, input bit lp);
    bit ss_e;
    bit lp_e;
    int old_count;
    if (rst) begin
      mode_m = 0; count_m = 0; lap_m = 0; run_cycles_m = 0;
      pend_m = 0; hold_m = 0; ovf_m = 0;
      ss_prev_m = ss; lap_prev_m = lp;
      disp_m = enc(0);
    end else begin
      ss_e = ss && !ss_prev_m;
      lp_e = lp && !lap_prev_m;
      ss_prev_m = ss;
      lap_prev_m = lp;
      disp_m = enc(hold_m ? lap_m : count_m);
      old_count = count_m;
      if (pend_m) begin
        count_m++;
        if (count_m == 100) begin
          count_m = 0;
          ovf_m = 1;
        end
      end
      pend_m = 0;
      if (mode_m == 1) begin
        pend_m = ((run_cycles_m % TD) == TD - 1);
        run_cycles_m++;
      end
      if (lp_e && !ss_e) begin
        if (hold_m) hold_m = 0;
        else if (mode_m == 1) begin
          hold_m = 1;
          lap_m = old_count;
        end
      end
      if (ss_e) mode_m = (mode_m == 1) ? 2 : 1;
    end
    exp_q.push_back({disp_m, (mode_m == 1), hold_m, ovf_m});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rst, input bit ss, input bit lp);
    @(negedge clk);
    reset = rst;
    start_stop = ss;
    lap = lp;
    model_step(rst, ss, lp);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0);
  endtask

  // Observe outputs right after the edge that applies the last drive.
  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("digits",   digits,   e[EW-1:3]);
        check("running",  running,  e[2]);
        check("lap_hold", lap_hold, e[1]);
        check("overflow", overflow, e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    bit found;
    int cnt;
    seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
    seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
    seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1101111;

    // Reset state
    drive(1, 0, 0);
    drive(1, 0, 0);
    peek();
    check("rst_digits",  digits,  {7'b0111111, 7'b0111111});
    check("rst_running", running, 0);
    check("rst_ovf",     overflow, 0);

    // Start, 42 edges later the display shows 10
    drive(0, 1, 0);
    idle(42);
    peek();
    check("ten_digits",  digits,  {7'b0000110, 7'b0111111});
    check("ten_running", running, 1);

    // Run past 99 -> 00 with sticky overflow
    idle(360);
    peek();
    check("wrap_digits", digits,   {7'b0111111, 7'b0111111});
    check("wrap_ovf",    overflow, 1);
    idle(30);
    peek();
    check("ovf_sticky",  overflow, 1);

    // Pause with prescaler at 2, resume: increment two cycles after resume
    drive(1, 0, 0);
    drive(0, 1, 0);
    idle(6);
    found = 0;
    for (int i = 0; i < 8; i++) begin
      if ((run_cycles_m % TD) == 2) begin
        found = 1;
        break;
      end
      drive(0, 0, 0);
    end
    check("presc2_reached", found, 1);
    drive(0, 1, 0);
    idle(20);
    drive(0, 1, 0);
    cnt = count_m;
    idle(2);
    peek();
    check("resume_hold", digits, enc(cnt));
    idle(1);
    peek();
    check("resume_step", digits, enc(cnt + 1));

    // Lap at 07, display frozen while live count reaches 12, then release
    drive(1, 0, 0);
    drive(0, 1, 0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (count_m == 7) begin
        found = 1;
        break;
      end
      drive(0, 0, 0);
    end
    check("count7_reached", found, 1);
    drive(0, 0, 1);
    idle(20);
    peek();
    check("lap_digits", digits,   {7'b0111111, 7'b0000111});
    check("lap_set",    lap_hold, 1);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (count_m == 12 && !pend_m) begin
        found = 1;
        break;
      end
      drive(0, 0, 0);
    end
    check("count12_reached", found, 1);
    drive(0, 0, 1);
    peek();
    check("lap_release", lap_hold, 0);
    idle(1);
    peek();
    check("live_digits", digits, {7'b0000110, 7'b1011011});

    // start_stop and lap edges together during RUN
    drive(0, 1, 1);
    peek();
    check("both_running", running,  0);
    check("both_lap",     lap_hold, 0);
    idle(3);

    // Reset during lap hold at 35 with start_stop held high
    drive(1, 0, 0);
    drive(0, 1, 0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (count_m == 35) begin
        found = 1;
        break;
      end
      drive(0, 0, 0);
    end
    check("count35_reached", found, 1);
    drive(0, 0, 1);
    drive(0, 0, 0);
    peek();
    check("hold35_set", lap_hold, 1);
    drive(1, 1, 0);
    drive(1, 1, 0);
    repeat (5) drive(0, 1, 0);
    peek();
    check("rst_hold_running", running,  0);
    check("rst_hold_lap",     lap_hold, 0);
    check("rst_hold_digits",  digits,   {7'b0111111, 7'b0111111});
    drive(0, 0, 0);

    // Randomized traffic with occasional resets
    drive(1, 0, 0);
    repeat (800) begin
      drive(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0));
    end

    idle(2);
    peek();
    check("queue_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of cascaded BCD decades (range 1..8).
REQ-002 SHALL have parameter TICK_DIV, default 1000000: clk cycles per count increment (range 1..2^24).
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 0: 1 inverts every segment output bit.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start_stop, input, 1: level input, synchronous to clk; rising edge toggles run/pause.
REQ-007 SHALL have port lap, input, 1: level input, synchronous to clk; rising edge captures/releases lap hold.
REQ-008 SHALL have port digits, output, 7*NUM_DIGITS: seven-seg codes, digit i (i=0 is ones) in bits [7i+6:7i], bit order gfedcba.
REQ-009 SHALL have port running, output, 1: high in RUN state.
REQ-010 SHALL have port lap_hold, output, 1: high while the display shows the frozen lap value.
REQ-011 SHALL have port overflow, output, 1: sticky; set on wrap from all-9s to all-0s.

Function
REQ-012 SHALL detect edges by comparing each input with its registered previous-cycle value; edge acts on the same clk edge it is sampled.
REQ-013 SHALL implement states IDLE, RUN, PAUSE; IDLE->RUN and PAUSE->RUN on start_stop edge; RUN->PAUSE on start_stop edge.
REQ-014 SHALL run a prescaler 0..TICK_DIV-1 only in RUN; terminal value produces a one-cycle tick and reloads 0; prescaler value SHALL be retained in PAUSE.
REQ-015 SHALL increment the BCD count by one on the clk edge following a tick; each decade wraps 9->0 and carries into the next.
REQ-016 SHALL wrap all-9s to all-0s and set overflow in the same cycle; counting continues.
REQ-017 SHALL, on lap edge in RUN with lap_hold=0, copy the live count into the lap register and set lap_hold; count continues.
REQ-018 SHALL, on lap edge with lap_hold=1 (RUN or PAUSE), clear lap_hold; lap edge in IDLE, or in PAUSE with lap_hold=0, is ignored.
REQ-019 SHALL give start_stop priority: when both edges occur in one cycle the state transition applies and the lap edge is ignored.
REQ-020 SHALL decode the displayed value (lap register if lap_hold, else live count) into registered segment outputs, one cycle after the displayed value changes.
REQ-021 SHALL use codes 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; non-BCD yields 0000000 (pre-inversion).

Reset
REQ-022 SHALL, with reset high at a clk edge, enter IDLE and clear prescaler, count, lap register, edge registers, lap_hold, overflow, running; digits SHALL show all zeros ("0" code each, inverted if SEG_ACTIVE_LOW) on the following cycle.
REQ-023 SHALL give reset priority over all edges, including mid-count and mid-lap-hold; edges sampled during reset SHALL not act after release (edge registers load current input level).

Structure
REQ-024 SHALL place state encoding constants and the seven-segment code table in shared package stopwatch_pkg.
REQ-025 SHALL instantiate sub-module bcd_decade (enable in, 4-bit digit, carry out) NUM_DIGITS times via generate.
REQ-026 SHALL contain no latches, no derived clocks, and no asynchronous logic.

Verification (NUM_DIGITS=2, TICK_DIV=4, SEG_ACTIVE_LOW=0)
REQ-027 SHALL cover: reset, start_stop pulse, wait 40 cycles -> count 10, digits = {0000110,0111111}, running=1.
REQ-028 SHALL cover: run to 99, 4 more cycles -> count 00, overflow=1 and stays 1 until reset.
REQ-029 SHALL cover: start_stop pulse at prescaler=2, hold 20 cycles, pulse again -> next increment exactly 2 cycles after resume.
REQ-030 SHALL cover: lap at count 07, run 20 cycles -> digits show 07 while live count reaches 12; second lap -> digits show 12 one cycle later.
REQ-031 SHALL cover: start_stop and lap edges in same cycle during RUN -> PAUSE entered, lap_hold remains 0.
REQ-032 SHALL cover: reset asserted with lap_hold=1 at count 35 and start_stop held high -> IDLE, all zeros, no RUN entry after release.
